// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: sequences fetch, decode and execute phases,
// stalls on the memory handshake and flags undecodable instructions.
module multicycle_ctrl #(
    parameter int unsigned EXT_BRANCH = 1,
    parameter int unsigned EXT_IMM    = 1,
    parameter int unsigned MEM_HS     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       alusign,
    input  logic       mem_ready,
    output logic       memreq,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       alusrca,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    localparam int unsigned ST_W  = 4;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;

    localparam logic [ST_W-1:0] S_FETCH   = ST_W'(0);
    localparam logic [ST_W-1:0] S_DECODE  = ST_W'(1);
    localparam logic [ST_W-1:0] S_MEMADR  = ST_W'(2);
    localparam logic [ST_W-1:0] S_MEMRD   = ST_W'(3);
    localparam logic [ST_W-1:0] S_MEMWB   = ST_W'(4);
    localparam logic [ST_W-1:0] S_MEMWR   = ST_W'(5);
    localparam logic [ST_W-1:0] S_RTYPEEX = ST_W'(6);
    localparam logic [ST_W-1:0] S_RTYPEWB = ST_W'(7);
    localparam logic [ST_W-1:0] S_BREX    = ST_W'(8);
    localparam logic [ST_W-1:0] S_IMMEX   = ST_W'(9);
    localparam logic [ST_W-1:0] S_IMMWB   = ST_W'(10);
    localparam logic [ST_W-1:0] S_JEX     = ST_W'(11);

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_BLEZ  = 6'b000110;
    localparam logic [OP_W-1:0] OP_BGTZ  = 6'b000111;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] F_ADD = 6'b100000;
    localparam logic [OP_W-1:0] F_SUB = 6'b100010;
    localparam logic [OP_W-1:0] F_AND = 6'b100100;
    localparam logic [OP_W-1:0] F_OR  = 6'b100101;
    localparam logic [OP_W-1:0] F_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    logic [ST_W-1:0]  state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [OP_W-1:0]  funct_q, funct_d;
    logic             mem_rdy;
    logic             funct_legal;
    logic [ST_W-1:0]  dec_next;
    logic             dec_illegal;
    logic [ALU_W-1:0] alu_rtype;
    logic [ALU_W-1:0] alu_imm;
    logic             take;

    assign mem_rdy = (MEM_HS != 0) ? mem_ready : 1'b1;
    assign state   = state_q;

    // State register plus the opcode/funct copy captured in DECODE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    always_comb begin
        op_d    = op_q;
        funct_d = funct_q;
        if (state_q == S_DECODE) begin
            op_d    = op;
            funct_d = funct;
        end
    end

    // Instruction decode on the live instruction bits while in DECODE.
    always_comb begin
        funct_legal = 1'b0;
        case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: funct_legal = 1'b1;
            default:                          funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_next    = S_FETCH;
        dec_illegal = 1'b0;
        case (op)
            OP_LW, OP_SW: dec_next = S_MEMADR;
            OP_RTYPE: begin
                if (funct_legal) dec_next = S_RTYPEEX;
                else             dec_illegal = 1'b1;
            end
            OP_BEQ:  dec_next = S_BREX;
            OP_BNE, OP_BLEZ, OP_BGTZ: begin
                if (EXT_BRANCH != 0) dec_next = S_BREX;
                else                 dec_illegal = 1'b1;
            end
            OP_ADDI: dec_next = S_IMMEX;
            OP_SLTI: begin
                if (EXT_IMM != 0) dec_next = S_IMMEX;
                else              dec_illegal = 1'b1;
            end
            OP_J:    dec_next = S_JEX;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Execute-phase controls come from the latched instruction copy.
    always_comb begin
        alu_rtype = ALU_ADD;
        case (funct_q)
            F_ADD:   alu_rtype = ALU_ADD;
            F_SUB:   alu_rtype = ALU_SUB;
            F_AND:   alu_rtype = ALU_AND;
            F_OR:    alu_rtype = ALU_OR;
            F_SLT:   alu_rtype = ALU_SLT;
            default: alu_rtype = ALU_ADD;
        endcase
    end

    assign alu_imm = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;

    always_comb begin
        take = 1'b0;
        case (op_q)
            OP_BEQ:  take = zero;
            OP_BNE:  take = ~zero;
            OP_BLEZ: take = alusign | zero;
            OP_BGTZ: take = ~(alusign | zero);
            default: take = 1'b0;
        endcase
    end

    // Next-state logic; unused codes fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_rdy ? S_DECODE : S_FETCH;
            S_DECODE:  state_d = dec_next;
            S_MEMADR:  state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = mem_rdy ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_RTYPEWB: state_d = S_FETCH;
            S_BREX:    state_d = S_FETCH;
            S_IMMEX:   state_d = S_IMMWB;
            S_IMMWB:   state_d = S_FETCH;
            S_JEX:     state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Output decode; during reset present FETCH selects with all enables off.
    always_comb begin
        memreq     = 1'b0;
        pcen       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        illegal    = 1'b0;
        if (!reset) begin
            alusrcb    = 2'b01;
            alucontrol = ALU_ADD;
        end else begin
            case (state_q)
                S_FETCH: begin
                    memreq     = 1'b1;
                    alusrcb    = 2'b01;
                    alucontrol = ALU_ADD;
                    irwrite    = mem_rdy;
                    pcen       = mem_rdy;
                end
                S_DECODE: begin
                    alusrcb    = 2'b11;
                    alucontrol = ALU_ADD;
                    illegal    = dec_illegal;
                end
                S_MEMADR: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = ALU_ADD;
                end
                S_MEMRD: begin
                    memreq = 1'b1;
                    iord   = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    memreq   = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_RTYPEEX: begin
                    alusrca    = 1'b1;
                    alucontrol = alu_rtype;
                end
                S_RTYPEWB: begin
                    regdst     = 1'b1;
                    regwrite   = 1'b1;
                    alucontrol = alu_rtype;
                end
                S_BREX: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = 2'b01;
                    pcen       = take;
                end
                S_IMMEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = alu_imm;
                end
                S_IMMWB: begin
                    regwrite   = 1'b1;
                    alucontrol = alu_imm;
                end
                S_JEX: begin
                    pcsrc = 2'b10;
                    pcen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
